layer_featuremap_accum: RTL and testbench
=========================================

// Module: layer_featuremap_accum
// PURPOSE
//  Parametrised per-output-feature-map channel combiner for the conv layers.
//  - Takes the CH_NUM per-input-channel 3x3 convolution results for one pixel.
//  - Sums them with a bias in a pipelined adder tree.
//  - Applies the selected activation, then saturates to DATA_WIDTH.
//  - Counts output pixels per IMG_SIZE x IMG_SIZE frame; reports frame completion and saturation statistics.
//  - Sits directly after the bank of Conv2D3x3 instances of one feature map.
// PARAMETERS
//  DATA_WIDTH  16   signed two's-complement sample width, per channel and output
//  FRAC_BITS   8    fractional bits of the fixed-point format (BIAS uses the same format)
//  CH_NUM      3    input channels summed per pixel, >=1
//  IMG_SIZE    416  frame is IMG_SIZE*IMG_SIZE output pixels
//  BIAS        0    signed DATA_WIDTH bias added to every pixel
//  ACT_MODE    2    0 = linear, 1 = ReLU, 2 = leaky ReLU (slope 1/8)
// PORTS
//  Clk         in   1                  clock, rising edge
//  Rst         in   1                  reset, asynchronous, active-low
//  data_in     in   CH_NUM*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  valid_in    in   1                  data_in holds a pixel this cycle
//  data_out    out  DATA_WIDTH         activated, saturated pixel
//  valid_out   out  1                  data_out valid this cycle
//  frame_done  out  1                  1-cycle pulse, coincident with the last pixel of a frame
//  busy        out  1                  frame in progress (FSM in RUN)
//  sat_count   out  16                 saturated pixels in the current or most recent frame
// BEHAVIOUR
//  - Reset: while Rst==0, all outputs are 0, the FSM is IDLE, the pipeline valid bits are cleared and all counters are 0.
//  - Reset asserted mid-frame discards all in-flight pixels and restarts the frame count.
//  - No backpressure. Every valid_in beat yields exactly one valid_out beat. Gaps in valid_in are allowed.
//  - Internal width: W = DATA_WIDTH + clog2(CH_NUM+1). Operands are sign-extended; there is no internal overflow.
//  - Adder tree: the CH_NUM+1 leaves are the channels plus BIAS.
//    - S = clog2(CH_NUM+1) registered levels. An odd element passes through a level registered.
//  - Final stage (1 register): activation on the W-bit sum, then saturation.
//    - Activation: ReLU maps negative values to 0.
//    - Activation: leaky maps negative x to x>>>3 (arithmetic shift, rounds toward -inf).
//    - Saturation: clamp to [-2^(DW-1), 2^(DW-1)-1].
//  - Latency: valid_in to valid_out is exactly S+1 cycles (CH_NUM=1: 2; CH_NUM=3: 3; CH_NUM=5: 4).
//    - Valid bits travel in a shift register alongside the data.
//  - FSM: IDLE -> RUN on valid_in==1.
//    - RUN -> IDLE in the cycle after the output beat that makes pix_cnt == IMG_SIZE^2 (frame_done asserted on that beat).
//    - busy = (state == RUN).
//    - A valid_in arriving in that same cycle starts the next frame. Its output counts toward the next frame.
//  - pix_cnt counts valid_out beats and wraps to 0 after the last pixel of a frame.
//  - sat_count:
//    - Cleared on the first output beat of a frame, which is itself counted if saturated.
//    - Increments on each valid_out beat whose value was clamped.
//    - Saturates at 16'hFFFF. Holds after frame_done until the next frame starts.
//  - data_out holds its last value when valid_out==0.
// TESTING (DATA_WIDTH=16, FRAC_BITS=8, CH_NUM=3, IMG_SIZE=4 unless stated)
//  1. ACT_MODE=0, BIAS=16'h0080, channels {0100,0200,FF00}, one beat
//     -> data_out=16'h0280 with valid_out exactly 3 cycles later.
//  2. Sum -16'h0400: ACT_MODE=2 -> 16'hFF80; ACT_MODE=1 -> 16'h0000.
//     Sum -1 with ACT_MODE=2 -> 16'hFFFF.
//  3. Channels 3x16'h7000 -> 16'h7FFF, then 3x16'h9000 -> 16'h8000.
//     -> sat_count=2 after both beats.
//  4. 16 valid beats with random gaps -> 16 valid_out beats.
//     -> frame_done high only with the 16th; busy low the cycle after.
//     -> A 17th beat raises busy and clears sat_count on its output.
//  5. Rst low for 1 cycle after 7 beats, mid-pipeline
//     -> in-flight outputs never appear; all outputs 0.
//     -> 16 further beats are needed for frame_done.
//  6. CH_NUM=1 and CH_NUM=5 builds, continuous valid_in
//     -> latency 2 and 4 respectively; one output per cycle, no drops.

Source files
------------

// File: rtl/layer_featuremap_accum.sv
// ---------------------------------------------------------------------------
// layer_featuremap_accum
//
// Channel combiner for one output feature map of a conv layer. It sits right
// after the Conv2D3x3 bank of that map. For each pixel it:
//   - adds the CH_NUM per-channel results and BIAS in a pipelined adder tree,
//   - applies the selected activation,
//   - saturates the result to DATA_WIDTH.
// It also counts output pixels per IMG_SIZE x IMG_SIZE frame, flags the last
// pixel of each frame, and keeps a count of saturated pixels for that frame.
//
// Ports
//   Clk         in   1                  clock, rising edge
//   Rst         in   1                  asynchronous reset, active-low
//   data_in     in   CH_NUM*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_in    in   1                  data_in carries a pixel this cycle
//   data_out    out  DATA_WIDTH         activated, saturated pixel
//   valid_out   out  1                  data_out valid this cycle
//   frame_done  out  1                  pulse coincident with last pixel of a frame
//   busy        out  1                  frame in progress
//   sat_count   out  16                 saturated pixels in current/most recent frame
//
// Latency from valid_in to valid_out is S+1 cycles, where S = clog2(CH_NUM+1).
// There is no backpressure: every input beat produces exactly one output beat.
// ---------------------------------------------------------------------------
module layer_featuremap_accum #(
    parameter int                            DATA_WIDTH = 16,
    parameter int                            FRAC_BITS  = 8,
    parameter int                            CH_NUM     = 3,
    parameter int                            IMG_SIZE   = 416,
    parameter logic signed [DATA_WIDTH-1:0]  BIAS       = '0,
    parameter int                            ACT_MODE   = 2
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic [CH_NUM*DATA_WIDTH-1:0]   data_in,
    input  logic                           valid_in,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           valid_out,
    output logic                           frame_done,
    output logic                           busy,
    output logic [15:0]                    sat_count
);

    // Tree geometry. The leaves are padded with zeros up to a power of two P.
    // Each node then adds exactly two children. A padded zero child is how an
    // odd element passes through a level registered.
    localparam int S         = $clog2(CH_NUM + 1);
    localparam int W         = DATA_WIDTH + S;
    localparam int P         = 1 << S;
    localparam int PIX_TOTAL = IMG_SIZE * IMG_SIZE;
    localparam int PIX_W     = $clog2(PIX_TOTAL + 1);

    localparam logic signed [W-1:0] SAT_MAX = {{(S + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [W-1:0] SAT_MIN = {{(S + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    if (CH_NUM < 1 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_param_err
        $error("layer_featuremap_accum: CH_NUM must be >= 1 and FRAC_BITS within DATA_WIDTH");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Leaves: sign-extended channels, then BIAS, then zero padding.
    // BIAS uses the same fixed-point format, so no alignment is needed.
    // ------------------------------------------------------------------
    logic signed [W-1:0] leaf [P];

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < CH_NUM) begin : g_ch
            assign leaf[i] = W'($signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]));
        end else if (i == CH_NUM) begin : g_bias
            assign leaf[i] = W'(BIAS);
        end else begin : g_pad
            assign leaf[i] = '0;
        end
    end

    // ------------------------------------------------------------------
    // Adder tree in heap order: node k has children 2k and 2k+1. Indices
    // k >= P/2 take their children directly from the leaves, so the root
    // (node 1) is S registers away from data_in.
    // ------------------------------------------------------------------
    logic signed [W-1:0] node_d [1:P-1];
    logic signed [W-1:0] node_q [1:P-1];

    for (genvar k = 1; k < P; k++) begin : g_node
        if (2 * k >= P) begin : g_from_leaf
            assign node_d[k] = leaf[2*k-P] + leaf[2*k+1-P];
        end else begin : g_from_node
            assign node_d[k] = node_q[2*k] + node_q[2*k+1];
        end
    end

    // NOTE: the tree data registers are not reset. Only the valid shift
    // register decides whether a value is consumed, so stale data is harmless.
    always_ff @(posedge Clk) begin
        node_q <= node_d;
    end

    // Valid bits move alongside the tree levels. Reset clears them, so any
    // pixel in flight when Rst is asserted is dropped.
    logic [S-1:0] vld_q;

    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the values from before the edge, whatever the block order.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | S'(valid_in);
        end
    end

    // ------------------------------------------------------------------
    // Final stage: activation on the full-width sum, then clamping.
    // ------------------------------------------------------------------
    logic signed [W-1:0]     act;
    logic [DATA_WIDTH-1:0]   clamped;
    logic                    sat_hit;

    // NOTE: every variable gets a default at the top of the block. Without it,
    // a path that skips the assignment would infer a latch.
    always_comb begin
        act = node_q[1];
        if (node_q[1] < 0) begin
            if (ACT_MODE == 1) begin
                act = '0;
            end else if (ACT_MODE == 2) begin
                act = node_q[1] >>> 3;      // slope 1/8, rounds toward -inf
            end
        end
    end

    always_comb begin
        sat_hit = 1'b0;
        clamped = act[DATA_WIDTH-1:0];
        if (act > SAT_MAX) begin
            sat_hit = 1'b1;
            clamped = SAT_MAX[DATA_WIDTH-1:0];
        end else if (act < SAT_MIN) begin
            sat_hit = 1'b1;
            clamped = SAT_MIN[DATA_WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Frame bookkeeping. It is driven by the beat that is about to leave
    // the final register, so it stays aligned with valid_out.
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic [PIX_W-1:0]       pix_cnt_q, pix_cnt_d;
    logic [15:0]            sat_cnt_q, sat_cnt_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   valid_out_q, frame_done_q;
    logic                   out_fire, first_pix, last_pix;

    assign out_fire  = vld_q[S-1];
    assign first_pix = (pix_cnt_q == '0);
    assign last_pix  = (pix_cnt_q == PIX_W'(PIX_TOTAL - 1));

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        data_out_d = data_out_q;
        if (out_fire) begin
            data_out_d = clamped;
            pix_cnt_d  = last_pix ? '0 : pix_cnt_q + 1'b1;
            // The first beat of a frame restarts the count and counts itself.
            if (first_pix) begin
                sat_cnt_d = {15'b0, sat_hit};
            end else if (sat_hit && sat_cnt_q != 16'hFFFF) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            sat_cnt_q    <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            sat_cnt_q    <= sat_cnt_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= out_fire;
            frame_done_q <= out_fire && last_pix;
            case (state_q)
                IDLE: if (valid_in) state_q <= RUN;
                // Leave RUN in the cycle after the last pixel of the frame,
                // unless a new pixel arrives in that cycle and opens the next frame.
                RUN:  if (frame_done_q && !valid_in) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == RUN);
    assign sat_count  = sat_cnt_q;

endmodule

// File: tb/tb_layer_featuremap_accum.sv
// ---------------------------------------------------------------------------
// tb_layer_featuremap_accum
//
// Five instances share one input stream:
//   u0: 3 ch, leaky,  bias 0
//   u1: 3 ch, linear, bias 0x0080
//   u2: 3 ch, ReLU,   bias 0
//   u3: 1 ch, leaky,  bias 0x0040
//   u4: 5 ch, leaky,  bias 0xFF00
// The frame is 4x4 pixels for every instance.
//
// For each beat, a reference model computes the expected pixel for every
// instance with plain integer arithmetic. It also predicts frame_done and
// sat_count for that beat, and stores the issue cycle. The results are queued
// per instance. A monitor pops an entry on every valid_out and compares data,
// frame_done, sat_count and latency.
// ---------------------------------------------------------------------------
module tb_layer_featuremap_accum;

    localparam int NI  = 5;
    localparam int PIX = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] chv [5];

    logic [15:0] dout [NI];
    logic [15:0] scnt [NI];
    logic        vout [NI];
    logic        fdone [NI];
    logic        busy [NI];

    always #5 clk = ~clk;

    // Per-instance configuration used by the model.
    int nch  [NI] = '{3, 3, 3, 1, 5};
    int mode [NI] = '{2, 0, 1, 2, 2};
    int bias [NI] = '{0, 128, 0, 64, -256};
    int lat  [NI] = '{3, 3, 3, 2, 4};

    typedef struct {
        logic [15:0] data;
        logic        fd;
        logic [15:0] sc;
        int          cyc;
    } exp_t;

    exp_t        sb [NI][$];
    int          pix_m [NI];
    int          sc_m [NI];
    logic [15:0] last_m [NI];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    layer_featuremap_accum #(.DATA_WIDTH(16), .FRAC_BITS(8), .CH_NUM(3), .IMG_SIZE(4),
                             .BIAS(16'h0000), .ACT_MODE(2)) u0 (
        .Clk(clk), .Rst(rst_n), .data_in({chv[2], chv[1], chv[0]}), .valid_in(valid_in),
        .data_out(dout[0]), .valid_out(vout[0]), .frame_done(fdone[0]), .busy(busy[0]),
        .sat_count(scnt[0]));

    layer_featuremap_accum #(.DATA_WIDTH(16), .FRAC_BITS(8), .CH_NUM(3), .IMG_SIZE(4),
                             .BIAS(16'h0080), .ACT_MODE(0)) u1 (
        .Clk(clk), .Rst(rst_n), .data_in({chv[2], chv[1], chv[0]}), .valid_in(valid_in),
        .data_out(dout[1]), .valid_out(vout[1]), .frame_done(fdone[1]), .busy(busy[1]),
        .sat_count(scnt[1]));

    layer_featuremap_accum #(.DATA_WIDTH(16), .FRAC_BITS(8), .CH_NUM(3), .IMG_SIZE(4),
                             .BIAS(16'h0000), .ACT_MODE(1)) u2 (
        .Clk(clk), .Rst(rst_n), .data_in({chv[2], chv[1], chv[0]}), .valid_in(valid_in),
        .data_out(dout[2]), .valid_out(vout[2]), .frame_done(fdone[2]), .busy(busy[2]),
        .sat_count(scnt[2]));

    layer_featuremap_accum #(.DATA_WIDTH(16), .FRAC_BITS(8), .CH_NUM(1), .IMG_SIZE(4),
                             .BIAS(16'h0040), .ACT_MODE(2)) u3 (
        .Clk(clk), .Rst(rst_n), .data_in(chv[0]), .valid_in(valid_in),
        .data_out(dout[3]), .valid_out(vout[3]), .frame_done(fdone[3]), .busy(busy[3]),
        .sat_count(scnt[3]));

    layer_featuremap_accum #(.DATA_WIDTH(16), .FRAC_BITS(8), .CH_NUM(5), .IMG_SIZE(4),
                             .BIAS(16'hFF00), .ACT_MODE(2)) u4 (
        .Clk(clk), .Rst(rst_n), .data_in({chv[4], chv[3], chv[2], chv[1], chv[0]}),
        .valid_in(valid_in), .data_out(dout[4]), .valid_out(vout[4]), .frame_done(fdone[4]),
        .busy(busy[4]), .sat_count(scnt[4]));

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: exact sum, activation, clamp, then frame bookkeeping.
    function automatic void model_push(input int k);
        longint s;
        bit     sat;
        exp_t   e;
        s   = bias[k];
        sat = 1'b0;
        for (int i = 0; i < nch[k]; i++) s += longint'($signed(chv[i]));
        if (s < 0 && mode[k] == 1) s = 0;
        else if (s < 0 && mode[k] == 2) s = (s - 7) / 8;   // floor(s/8) for negative s
        if (s > 32767) begin
            s = 32767;
            sat = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            sat = 1'b1;
        end
        if (pix_m[k] == 0) sc_m[k] = sat ? 1 : 0;
        else if (sat && sc_m[k] < 65535) sc_m[k]++;
        e.data = 16'(s);
        e.fd   = (pix_m[k] == PIX - 1);
        e.sc   = 16'(sc_m[k]);
        e.cyc  = cyc;
        sb[k].push_back(e);
        pix_m[k] = (pix_m[k] + 1) % PIX;
    endfunction

    function automatic logic [15:0] rnd16();
        if ($urandom_range(0, 3) == 0) return 16'($urandom());
        return 16'($urandom_range(0, 16'h0600)) - 16'h0300;
    endfunction

    task automatic beat(input logic [15:0] a, b, c, d, e);
        @(posedge clk);
        #1;
        chv[0] = a; chv[1] = b; chv[2] = c; chv[3] = d; chv[4] = e;
        valid_in = 1'b1;
        for (int k = 0; k < NI; k++) model_push(k);
    endtask

    task automatic rbeat();
        beat(rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    endtask

    // Idle cycles carry random data so ignored inputs are really ignored.
    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            for (int i = 0; i < 5; i++) chv[i] = rnd16();
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < NI; k++)
            check($sformatf("%s_u%0d_outputs", tag, k),
                  {dout[k], scnt[k], vout[k], fdone[k], busy[k]}, 64'd0);
    endtask

    // One-cycle reset: it drops every in-flight pixel and restarts the frame count.
    task automatic do_reset();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            sb[k].delete();
            pix_m[k] = 0;
            sc_m[k] = 0;
            last_m[k] = '0;
        end
        #1;
        check_zero("rst_async");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst_n = 1'b1;
    endtask

    task automatic wait_frame_done(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (fdone[0]) found = 1'b1;
        end
        check({tag, "_frame_done_seen"}, found, 1'b1);
        check({tag, "_busy_on_done"}, busy[0], 1'b1);
        @(negedge clk);
        check({tag, "_busy_after_done"}, busy[0], 1'b0);
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
                if (vout[k]) begin
                    if (sb[k].size() == 0) begin
                        check($sformatf("u%0d_unexpected_valid", k), 1'b1, 1'b0);
                    end else begin
                        e = sb[k].pop_front();
                        check($sformatf("u%0d_data", k), dout[k], e.data);
                        check($sformatf("u%0d_frame_done", k), fdone[k], e.fd);
                        check($sformatf("u%0d_sat_count", k), scnt[k], e.sc);
                        check($sformatf("u%0d_latency", k), 64'(cyc - e.cyc), 64'(lat[k]));
                        last_m[k] = e.data;
                    end
                end else begin
                    check($sformatf("u%0d_hold", k), dout[k], last_m[k]);
                    check($sformatf("u%0d_done_without_valid", k), fdone[k], 1'b0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) chv[i] = '0;
        for (int k = 0; k < NI; k++) begin
            pix_m[k] = 0;
            sc_m[k] = 0;
            last_m[k] = '0;
        end
        @(posedge clk);
        #1;
        check_zero("por");
        rst_n = 1'b1;
        gap(2);
        for (int k = 0; k < NI; k++) check($sformatf("u%0d_idle_busy", k), busy[k], 1'b0);

        // Linear with bias, a sum of -0x0400 and of -1, then clamping both ways.
        beat(16'h0100, 16'h0200, 16'hFF00, 16'h0000, 16'h0000);
        gap(4);
        beat(16'hFC00, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        beat(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        gap(2);
        beat(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
        beat(16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h9000);
        gap(4);
        check("busy_mid_frame", busy[0], 1'b1);

        // Full frame with random gaps; the first pixel saturates.
        do_reset();
        beat(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000);
        gap($urandom_range(0, 2));
        for (int i = 1; i < PIX; i++) begin
            rbeat();
            gap($urandom_range(0, 2));
        end
        gap(1);
        wait_frame_done("frame1");
        // Next frame opens: busy returns and sat_count restarts from this pixel.
        beat(16'h0010, 16'h0020, 16'h0000, 16'h0000, 16'h0000);
        gap(1);
        @(negedge clk);
        check("busy_next_frame", busy[0], 1'b1);
        gap(4);

        // Reset while pixels are in the pipeline, then a complete new frame.
        do_reset();
        for (int i = 0; i < 7; i++) rbeat();
        do_reset();
        for (int i = 0; i < PIX; i++) rbeat();
        gap(1);
        wait_frame_done("after_reset");

        // Continuous stream across several frames.
        for (int i = 0; i < 40; i++) rbeat();
        gap(8);
        for (int k = 0; k < NI; k++) check($sformatf("u%0d_drained", k), 64'(sb[k].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
